// File: rtl/net_pkg.sv
// ============================================================================
// Module      : net_pkg
// Description : Route encoding and header field width helpers for ring routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package net_pkg;

    typedef enum logic [1:0] {
        ROUTE_WEST = 2'd0,
        ROUTE_TERM = 2'd1,
        ROUTE_EAST = 2'd2
    } route_e;

    localparam int C_OPAQUE_NBITS = 8;

    function automatic int node_id_nbits(input int num_nodes);
        return (num_nodes > 1) ? $clog2(num_nodes) : 1;
    endfunction

    // dest + src + opaque byte; the payload fills whatever remains
    function automatic int hdr_nbits(input int num_nodes);
        return 2 * node_id_nbits(num_nodes) + C_OPAQUE_NBITS;
    endfunction

    function automatic logic [2:0] route_onehot(input route_e route);
        logic [2:0] onehot;
        onehot = 3'b000;
        case (route)
            ROUTE_WEST: onehot = 3'b001;
            ROUTE_TERM: onehot = 3'b010;
            ROUTE_EAST: onehot = 3'b100;
            default:    onehot = 3'b000;
        endcase
        return onehot;
    endfunction

endpackage

`default_nettype wire

// File: rtl/net_route_compute.sv
// ============================================================================
// Module      : net_route_compute
// Description : Combinational ring route selection from a destination id.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module net_route_compute
    import net_pkg::*;
#(
    parameter int P_NUM_NODES = 4,
    parameter int P_ID_NBITS  = node_id_nbits(P_NUM_NODES)
) (
    input  logic [P_ID_NBITS-1:0] dest,
    input  logic [P_ID_NBITS-1:0] router_id,
    output route_e                route
);

    localparam logic [P_ID_NBITS:0] C_HALF = (P_ID_NBITS + 1)'(P_NUM_NODES / 2);

    // Node count is a power of two, so plain subtraction wraps modulo the ring size
    logic [P_ID_NBITS-1:0] w_dist;

    always_comb begin
        w_dist = dest - router_id;
        route  = ROUTE_EAST;
        if (dest == router_id) begin
            route = ROUTE_TERM;
        end else if ({1'b0, w_dist} > C_HALF) begin
            route = ROUTE_WEST;
        end
    end

endmodule

`default_nettype wire

// File: rtl/net_route_buffer.sv
// ============================================================================
// Module      : net_route_buffer
// Description : Input FIFO of a ring router steering its head to W/T/E outputs.
//               Define NET_ROUTE_BUFFER_BYPASS_EN for empty-FIFO cut-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module net_route_buffer
    import net_pkg::*;
#(
    parameter int p_msg_nbits = 44,
    parameter int p_num_nodes = 4,
    parameter int p_router_id = 0,
    parameter int p_depth     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_val,
    output logic                           in_rdy,
    input  logic [p_msg_nbits-1:0]         in_msg,
    output logic [2:0]                     out_val,
    input  logic [2:0]                     out_rdy,
    output logic [p_msg_nbits-1:0]         out_msg,
    output logic [$clog2(p_depth+1)-1:0]   num_free
);

    localparam int C_ID_NBITS  = node_id_nbits(p_num_nodes);
    localparam int C_PTR_NBITS = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int C_CNT_NBITS = $clog2(p_depth + 1);
    localparam int C_DEST_MSB  = p_msg_nbits - 1;
    localparam int C_DEST_LSB  = p_msg_nbits - C_ID_NBITS;

    localparam logic [C_PTR_NBITS-1:0] C_PTR_LAST  = C_PTR_NBITS'(p_depth - 1);
    localparam logic [C_CNT_NBITS-1:0] C_DEPTH     = C_CNT_NBITS'(p_depth);
    localparam logic [C_ID_NBITS-1:0]  C_ROUTER_ID = C_ID_NBITS'(p_router_id);

    generate
        if (p_msg_nbits < hdr_nbits(p_num_nodes)) begin : g_bad_msg_width
            $error("net_route_buffer: p_msg_nbits too small for header");
        end
        if ((p_num_nodes < 2) || ((p_num_nodes & (p_num_nodes - 1)) != 0)) begin : g_bad_num_nodes
            $error("net_route_buffer: p_num_nodes must be a power of two >= 2");
        end
        if (p_depth < 1) begin : g_bad_depth
            $error("net_route_buffer: p_depth must be >= 1");
        end
    endgenerate

    logic [p_msg_nbits-1:0] mem_q [p_depth];
    logic [C_PTR_NBITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PTR_NBITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_CNT_NBITS-1:0] count_q,  count_d;

    logic [p_msg_nbits-1:0] w_head_msg;
    route_e                 w_head_route;
    logic                   w_empty;
    logic                   w_bypass_take;
    logic                   w_enq;
    logic                   w_deq;

    assign w_head_msg = mem_q[rd_ptr_q];
    assign w_empty    = (count_q == '0);
    assign in_rdy     = (count_q < C_DEPTH);
    assign num_free   = C_DEPTH - count_q;

    net_route_compute #(
        .P_NUM_NODES (p_num_nodes)
    ) u_head_route (
        .dest      (w_head_msg[C_DEST_MSB:C_DEST_LSB]),
        .router_id (C_ROUTER_ID),
        .route     (w_head_route)
    );

`ifdef NET_ROUTE_BUFFER_BYPASS_EN
    route_e w_in_route;

    net_route_compute #(
        .P_NUM_NODES (p_num_nodes)
    ) u_in_route (
        .dest      (in_msg[C_DEST_MSB:C_DEST_LSB]),
        .router_id (C_ROUTER_ID),
        .route     (w_in_route)
    );

    // An empty FIFO presents the incoming message directly; it is only
    // stored if the selected output refuses it this cycle
    always_comb begin
        out_val = 3'b000;
        out_msg = w_head_msg;
        if (!w_empty) begin
            out_val = route_onehot(w_head_route);
        end else if (in_val) begin
            out_val = route_onehot(w_in_route);
            out_msg = in_msg;
        end
    end

    assign w_bypass_take = w_empty && in_val && (|(out_val & out_rdy));
`else
    always_comb begin
        out_val = w_empty ? 3'b000 : route_onehot(w_head_route);
        out_msg = w_head_msg;
    end

    assign w_bypass_take = 1'b0;
`endif

    assign w_deq = !w_empty && (|(out_val & out_rdy));
    assign w_enq = in_val && in_rdy && !w_bypass_take;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_enq) begin
            wr_ptr_d = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_deq) begin
            rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({w_enq, w_deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by count, so it carries no reset
    always_ff @(posedge clk) begin
        if (w_enq) begin
            mem_q[wr_ptr_q] <= in_msg;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_net_route_buffer.sv
// ============================================================================
// Module      : tb_net_route_buffer
// Description : Self-checking bench for net_route_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_net_route_buffer;

    localparam int NB  = 44;
    localparam int NN  = 4;
    localparam int RID = 1;
    localparam int DEP = 2;
    localparam int IDW = $clog2(NN);
`ifdef NET_ROUTE_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                         clk;
    logic                         reset;
    logic                         in_val;
    logic                         in_rdy;
    logic [NB-1:0]                in_msg;
    logic [2:0]                   out_val;
    logic [2:0]                   out_rdy;
    logic [NB-1:0]                out_msg;
    logic [$clog2(DEP+1)-1:0]     num_free;

    net_route_buffer #(
        .p_msg_nbits (NB),
        .p_num_nodes (NN),
        .p_router_id (RID),
        .p_depth     (DEP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_msg   (in_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .num_free (num_free)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [NB-1:0] q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output port one-hot for a message, straight from the ring distance rule
    function automatic logic [2:0] ref_route(input logic [NB-1:0] m);
        int dest;
        int d;
        dest = int'(m[NB-1 -: IDW]);
        if (dest == RID) return 3'b010;
        d = (dest - RID + NN) % NN;
        if (d < NN / 2) return 3'b100;
        if (d > NN / 2) return 3'b001;
        return 3'b100;
    endfunction

    function automatic logic [NB-1:0] mk_msg(input int dest);
        logic [NB-1:0] m;
        m = {$urandom, $urandom};
        m[NB-1 -: IDW] = IDW'(dest);
        return m;
    endfunction

    task automatic step(input logic v, input logic [NB-1:0] m, input logic [2:0] r, input string tag);
        logic [2:0]    ev;
        logic [NB-1:0] em;
        bit            erdy;
        bit            pass;
        @(negedge clk);
        in_val  = v;
        in_msg  = m;
        out_rdy = r;
        #1;
        erdy = (q.size() < DEP);
        ev   = 3'b000;
        em   = '0;
        if (q.size() > 0) begin
            ev = ref_route(q[0]);
            em = q[0];
        end else if (BYP && v) begin
            ev = ref_route(m);
            em = m;
        end
        check({tag, ".in_rdy"}, 64'(in_rdy), 64'(erdy));
        check({tag, ".num_free"}, 64'(num_free), 64'(DEP - q.size()));
        check({tag, ".out_val"}, 64'(out_val), 64'(ev));
        if (ev != 3'b000) check({tag, ".out_msg"}, 64'(out_msg), 64'(em));
        pass = BYP && (q.size() == 0) && v && ((ev & r) != 3'b000);
        @(posedge clk);
        if (((ev & r) != 3'b000) && (q.size() > 0)) void'(q.pop_front());
        if (v && erdy && !pass) q.push_back(m);
    endtask

    logic [NB-1:0] m_a;
    logic [NB-1:0] m_b;
    logic [NB-1:0] m_c;

    initial begin
        reset   = 1'b1;
        in_val  = 1'b0;
        in_msg  = '0;
        out_rdy = 3'b000;
        #1;
        check("rst.out_val", 64'(out_val), 64'd0);
        check("rst.in_rdy", 64'(in_rdy), 64'd1);
        check("rst.num_free", 64'(num_free), 64'(DEP));
        #20;
        @(negedge clk);
        reset = 1'b0;

        // terminal delivery
        m_a = mk_msg(1);
        step(1'b1, m_a, 3'b111, "term_enq");
        step(1'b0, '0, 3'b111, "term_deq");
        step(1'b0, '0, 3'b111, "term_idle");

        // east, west, tie-east in order
        step(1'b1, mk_msg(2), 3'b111, "seq0");
        step(1'b1, mk_msg(0), 3'b111, "seq1");
        step(1'b1, mk_msg(3), 3'b111, "seq2");
        step(1'b0, '0, 3'b111, "seq3");
        step(1'b0, '0, 3'b111, "seq4");

        // fill, back-pressure, release
        m_a = mk_msg(1);
        m_b = mk_msg(2);
        m_c = mk_msg(3);
        step(1'b1, m_a, 3'b000, "full0");
        step(1'b1, m_b, 3'b000, "full1");
        step(1'b1, m_c, 3'b000, "full2");
        step(1'b1, m_c, 3'b000, "full3");
        step(1'b1, m_c, 3'b111, "full4");
        step(1'b1, m_c, 3'b000, "full5");
        repeat (4) step(1'b0, '0, 3'b111, "full_drain");

        // head-of-line blocking on west
        step(1'b1, mk_msg(0), 3'b110, "hol0");
        step(1'b1, mk_msg(2), 3'b110, "hol1");
        step(1'b0, '0, 3'b110, "hol2");
        step(1'b0, '0, 3'b110, "hol3");
        step(1'b0, '0, 3'b001, "hol4");
        step(1'b0, '0, 3'b001, "hol5");
        step(1'b0, '0, 3'b111, "hol6");
        step(1'b0, '0, 3'b111, "hol7");

        // asynchronous reset with two entries held
        step(1'b1, mk_msg(3), 3'b000, "mrst0");
        step(1'b1, mk_msg(0), 3'b000, "mrst1");
        @(negedge clk);
        in_val  = 1'b0;
        out_rdy = 3'b111;
        #2;
        reset = 1'b1;
        #1;
        check("mrst.out_val", 64'(out_val), 64'd0);
        check("mrst.in_rdy", 64'(in_rdy), 64'd1);
        check("mrst.num_free", 64'(num_free), 64'(DEP));
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step(1'b0, '0, 3'b111, "mrst_after");

        // cut-through candidate on an empty buffer
        step(1'b1, mk_msg(1), 3'b010, "byp0");
        step(1'b0, '0, 3'b111, "byp1");
        step(1'b1, mk_msg(2), 3'b010, "byp2");
        step(1'b0, '0, 3'b111, "byp3");

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), mk_msg($urandom_range(0, NN - 1)),
                 3'($urandom_range(0, 7)), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
